// File: rtl/polyvec_unpack_stream.sv
// Streaming unpacker for Kyber polynomial vectors: packed COEFF_BITS-wide beats in, zero-extended
// LANES-wide words out with frame address, polynomial index and last flag. Define UNPACK_MODQ_CHECK_EN for the mod-q check.
module polyvec_unpack_stream #(
  parameter int KYBER_K_MAX = 4,
  parameter int KYBER_N     = 256,
  parameter int COEFF_BITS  = 12,
  parameter int LANES       = 8,
  parameter int OUT_LANE_W  = 16,
  parameter int KYBER_Q     = 3329,
  parameter int IN_W        = COEFF_BITS * LANES,
  parameter int AD_W        = $clog2(KYBER_K_MAX * KYBER_N / LANES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [2:0]                  k_sel,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_W-1:0]             in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [AD_W-1:0]             out_addr,
  output logic [2:0]                  out_poly,
  output logic                        out_last,
  output logic [LANES*OUT_LANE_W-1:0] out_data,
  output logic                        busy,
  output logic                        done,
  output logic                        err_modq
);

  localparam int WPP       = KYBER_N / LANES;
  localparam int MAX_WORDS = KYBER_K_MAX * WPP;
  localparam int CNT_W     = $clog2(MAX_WORDS + 1);
  localparam logic [2:0] K_MAX_3 = 3'(KYBER_K_MAX);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                      r_state;
  logic [CNT_W-1:0]            r_in_cnt;
  logic [CNT_W-1:0]            r_total;
  logic                        r_out_valid;
  logic [AD_W-1:0]             r_out_addr;
  logic [2:0]                  r_out_poly;
  logic                        r_out_last;
  logic [LANES*OUT_LANE_W-1:0] r_out_data;
  logic                        r_busy;
  logic                        r_done;

  logic [2:0]                  w_k_clamped;
  logic                        w_in_ready;
  logic                        w_in_fire;
  logic                        w_out_fire;
  logic [LANES*OUT_LANE_W-1:0] w_unpacked;

  assign w_k_clamped = (k_sel == 3'd0 || k_sel > K_MAX_3) ? K_MAX_3 : k_sel;

  // A new beat is only taken when the output register is empty or draining this cycle.
  assign w_in_ready = (r_state == S_RUN) && (r_in_cnt < r_total) && (!r_out_valid || out_ready);
  assign w_in_fire  = in_valid && w_in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  // NOTE: every combinational output gets a default before the loop so no latch is inferred.
  always_comb begin
    w_unpacked = '0;
    for (int j = 0; j < LANES; j++) begin
      w_unpacked[j*OUT_LANE_W +: COEFF_BITS] = in_data[j*COEFF_BITS +: COEFF_BITS];
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_cnt    <= '0;
      r_total     <= '0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_poly  <= '0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state  <= S_RUN;
            r_busy   <= 1'b1;
            r_in_cnt <= '0;
            r_total  <= CNT_W'(32'(w_k_clamped) * WPP);
          end
        end
        S_RUN: begin
          if (w_in_fire) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_unpacked;
            r_out_addr  <= AD_W'(r_in_cnt);
            r_out_poly  <= 3'(r_in_cnt / CNT_W'(WPP));
            r_out_last  <= (r_in_cnt == r_total - CNT_W'(1));
            r_in_cnt    <= r_in_cnt + CNT_W'(1);
          end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
          end
          // The final word cannot coincide with a new beat: in_cnt has already reached the total.
          if (w_out_fire && r_out_last) begin
            r_state    <= S_DONE;
            r_done     <= 1'b1;
            r_out_last <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef UNPACK_MODQ_CHECK_EN
  logic w_modq_hit;
  logic r_err_modq;

  if (COEFF_BITS == 12) begin : g_modq
    always_comb begin
      w_modq_hit = 1'b0;
      for (int j = 0; j < LANES; j++) begin
        if (in_data[j*COEFF_BITS +: COEFF_BITS] >= COEFF_BITS'(KYBER_Q)) w_modq_hit = 1'b1;
      end
    end
  end else begin : g_no_modq
    assign w_modq_hit = 1'b0;
  end

  // Sticky until the next accepted start; data passes through regardless.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_modq <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_err_modq <= 1'b0;
    end else if (w_in_fire && w_modq_hit) begin
      r_err_modq <= 1'b1;
    end
  end

  assign err_modq = r_err_modq;
`else
  assign err_modq = 1'b0;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_addr  = r_out_addr;
  assign out_poly  = r_out_poly;
  assign out_last  = r_out_last;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_polyvec_unpack_stream.sv
// Self-checking bench for polyvec_unpack_stream: a table of frame scenarios plus hand-written
// corner sequences, all scored against a queue-based reference model of the frame.
module tb_polyvec_unpack_stream;

  localparam int K_MAX = 4;
  localparam int N     = 256;
  localparam int CB    = 12;
  localparam int LN    = 8;
  localparam int OLW   = 16;
  localparam int Q     = 3329;
  localparam int IN_W  = CB * LN;
  localparam int OUT_W = OLW * LN;
  localparam int AD_W  = 7;
  localparam int WPP   = N / LN;
`ifdef UNPACK_MODQ_CHECK_EN
  localparam bit MQ = 1'b1;
`else
  localparam bit MQ = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       k_sel;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [AD_W-1:0]  out_addr;
  logic [2:0]       out_poly;
  logic             out_last;
  logic [OUT_W-1:0] out_data;
  logic             busy;
  logic             done;
  logic             err_modq;

  polyvec_unpack_stream #(
    .KYBER_K_MAX(K_MAX), .KYBER_N(N), .COEFF_BITS(CB), .LANES(LN),
    .OUT_LANE_W(OLW), .KYBER_Q(Q)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .k_sel(k_sel),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_poly(out_poly), .out_last(out_last), .out_data(out_data),
    .busy(busy), .done(done), .err_modq(err_modq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [AD_W-1:0]  addr;
    logic [2:0]       poly;
    logic             last;
  } exp_word_t;

  typedef struct {
    logic [2:0] k;
    int         stall;     // 0 always ready, 1 ready pattern 1,0,0,1, 2 random
    int         vmode;     // 0 always valid, 1 random valid
    int         dmode;     // 0 counting pattern, 1 random, 2 all ones, 3 single 0xD01 lane
    int         exp_words;
  } frame_vec_t;

  int n_pass  = 0;
  int n_total = 0;
  bit err_exp = 1'b0;

  task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [IN_W-1:0] gen(input int dmode, input int w);
    logic [IN_W-1:0] d;
    d = '0;
    case (dmode)
      0: for (int j = 0; j < LN; j++) d[j*CB +: CB] = CB'(w * LN + j + 1);
      1: d = {$urandom, $urandom, $urandom};
      2: d = '1;
      default: if (w == 0) d[3*CB +: CB] = 12'hD01;
    endcase
    return d;
  endfunction

  function automatic logic [OUT_W-1:0] expand(input logic [IN_W-1:0] b);
    logic [OUT_W-1:0] u;
    u = '0;
    for (int j = 0; j < LN; j++) u[j*OLW +: OLW] = {4'h0, b[j*CB +: CB]};
    return u;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_addr"}, out_addr, '0);
    check({tag, "_out_poly"}, out_poly, '0);
    check({tag, "_out_last"}, out_last, 1'b0);
    check({tag, "_out_data"}, out_data, '0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_err_modq"}, err_modq, 1'b0);
  endtask

  task automatic run_frame(input logic [2:0] k, input int stall, input int vmode, input int dmode,
                           input int exp_words, input int start_at, input int rst_at);
    exp_word_t        q[$];
    exp_word_t        e;
    int               n_in = 0;
    int               n_out = 0;
    int               cyc = 0;
    bit               run_phase;
    bit               done_exp;
    bit               stalled = 1'b0;
    bit               restarted = 1'b0;
    logic [OUT_W-1:0] held_data = '0;
    logic [AD_W-1:0]  held_addr = '0;
    logic [3:0]       tog = 4'b1001;

    @(posedge clk); #1;
    start = 1'b1; k_sel = k; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; k_sel = 3'd2;
    err_exp = 1'b0; run_phase = 1'b1; done_exp = 1'b0;
    check("busy_after_start", busy, 1'b1);

    while ((run_phase || done_exp) && cyc < 4000) begin
      if (rst_at >= 0 && n_in == rst_at) begin
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        err_exp = 1'b0;
        check_idle_outputs("after_rst");
        @(posedge clk); #1;
        @(negedge clk);
        check("no_done_after_rst", done, 1'b0);
        return;
      end
      if (start_at >= 0 && n_in == start_at && !restarted) begin
        start = 1'b1; k_sel = 3'd1; restarted = 1'b1;
      end
      in_valid  = (vmode == 0) ? 1'b1 : ($urandom_range(3) != 0);
      in_data   = gen(dmode, n_in);
      out_ready = (stall == 0) ? 1'b1 : (stall == 1) ? tog[cyc % 4] : ($urandom_range(2) != 0);

      @(negedge clk);
      check("out_valid", out_valid, q.size() != 0);
      check("done", done, done_exp);
      check("busy", busy, run_phase || done_exp);
      check("in_ready", in_ready, run_phase && n_in < exp_words && (q.size() == 0 || out_ready));
      check("err_modq", err_modq, err_exp);
      if (stalled) begin
        check("hold_data", out_data, held_data);
        check("hold_addr", out_addr, held_addr);
      end
      done_exp = 1'b0;

      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_word", 1'b1, 1'b0);
        end else begin
          e = q.pop_front();
          check("out_data", out_data, e.data);
          check("out_addr", out_addr, e.addr);
          check("out_poly", out_poly, e.poly);
          check("out_last", out_last, e.last);
          if (dmode == 0 && e.addr == 0)
            check("word0", out_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
          if (dmode == 2) check("all_ones_word", out_data, {LN{16'h0FFF}});
          if (dmode == 3 && e.addr == 0) check("modq_lane", out_data[3*OLW +: OLW], 16'h0D01);
          if (e.last) begin
            run_phase = 1'b0;
            done_exp  = 1'b1;
          end
          n_out++;
        end
      end
      stalled   = out_valid && !out_ready;
      held_data = out_data;
      held_addr = out_addr;

      if (in_valid && in_ready) begin
        e.data = expand(in_data);
        e.addr = AD_W'(n_in);
        e.poly = 3'(n_in / WPP);
        e.last = (n_in == exp_words - 1);
        q.push_back(e);
        for (int j = 0; j < LN; j++)
          if (MQ && in_data[j*CB +: CB] >= 12'(Q)) err_exp = 1'b1;
        n_in++;
      end

      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end

    if (run_phase || done_exp) check("frame_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check("post_busy", busy, 1'b0);
    check("post_done", done, 1'b0);
    check("post_in_ready", in_ready, 1'b0);
    check("post_out_valid", out_valid, 1'b0);
    check("post_err_modq", err_modq, err_exp);
    check("word_count", 32'(n_out), 32'(exp_words));
  endtask

  frame_vec_t vecs[7];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{k: 3'd2, stall: 0, vmode: 0, dmode: 0, exp_words: 64};
    vecs[1] = '{k: 3'd2, stall: 1, vmode: 0, dmode: 0, exp_words: 64};
    vecs[2] = '{k: 3'd4, stall: 0, vmode: 0, dmode: 2, exp_words: 128};
    vecs[3] = '{k: 3'd0, stall: 2, vmode: 1, dmode: 1, exp_words: 128};
    vecs[4] = '{k: 3'd7, stall: 2, vmode: 1, dmode: 1, exp_words: 128};
    vecs[5] = '{k: 3'd1, stall: 0, vmode: 1, dmode: 1, exp_words: 32};
    vecs[6] = '{k: 3'd3, stall: 1, vmode: 0, dmode: 1, exp_words: 96};

    rst = 1'b1; start = 1'b0; k_sel = 3'd0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_frame(vecs[i].k, vecs[i].stall, vecs[i].vmode, vecs[i].dmode, vecs[i].exp_words, -1, -1);

    // start pulsed mid-frame must be ignored
    run_frame(3'd2, 0, 0, 0, 64, 5, -1);
    // reset after 20 accepted beats, then a clean full frame
    run_frame(3'd2, 0, 0, 0, 64, -1, 20);
    run_frame(3'd2, 2, 1, 0, 64, -1, -1);
    // out-of-range lane, then a frame whose start clears the sticky flag
    run_frame(3'd1, 0, 0, 3, 32, -1, -1);
    run_frame(3'd1, 0, 0, 0, 32, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
